// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with a small receive FIFO
//
// Ports:
//   CLK        system clock, all logic on the rising edge
//   RST        synchronous active-high reset
//   RX         asynchronous serial input, idle high
//   RD_POP     one-cycle strobe, pops the FIFO head (ignored when empty)
//   ERR_CLR    clears FRAME_ERR and OVERRUN
//   DATA       FIFO head byte, 8'h00 when empty
//   RX_READY   FIFO non-empty
//   FRAME_ERR  sticky, a stop bit was sampled low
//   OVERRUN    sticky, a byte was dropped because the FIFO was full
//   RX_INT     one-cycle pulse per byte written into the FIFO

module uart_receiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  input  logic       RD_POP,
  input  logic       ERR_CLR,
  output logic [7:0] DATA,
  output logic       RX_READY,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       RX_INT
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int NW   = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rx_meta;
  logic          rx_s;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [NW-1:0] count;

  logic          stop_sample;
  logic          push_req;
  logic          push_ok;
  logic          pop;

  // Two-flop synchroniser; idle-high so reset must not look like a start bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    stop_sample = (state == S_STOP) && (cnt == CW'(CLKS_PER_BIT - 1));
    push_req    = stop_sample && rx_s;
    pop         = RD_POP && (count != '0);
    // A pop in the same cycle frees the slot even when the FIFO is full.
    push_ok     = push_req && ((count < NW'(FIFO_DEPTH)) || RD_POP);
  end

  // Frame FSM. The counter restarts on every state entry and after each
  // sample, so the start sample lands mid-bit and later samples follow
  // one full bit period apart.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= S_START;
          end
        end
        S_START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt <= '0;
            if (rx_s) begin
              state <= S_IDLE;  // glitch, not a real start bit
            end else begin
              state   <= S_DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (stop_sample) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Storage array carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= shift;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      RX_INT    <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      RX_INT <= push_ok;
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase

      // Setting beats clearing when both happen in the same cycle.
      if (stop_sample && !rx_s) begin
        FRAME_ERR <= 1'b1;
      end else if (ERR_CLR) begin
        FRAME_ERR <= 1'b0;
      end
      if (push_req && !push_ok) begin
        OVERRUN <= 1'b1;
      end else if (ERR_CLR) begin
        OVERRUN <= 1'b0;
      end
    end
  end

  assign RX_READY = (count != '0);
  assign DATA     = (count != '0) ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed table-driven bench for uart_receiver

module tb_uart_receiver;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME_TICKS = 160;
  localparam int GAP_TICKS   = 20;
  localparam int PUSH_TICK   = 155;  // T0 is tick 3, push seen at T0+152 edge

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rd_pop;
  logic       err_clr;
  logic [7:0] data;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       rx_int;

  int checks;
  int errors;

  uart_receiver #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .RX       (rx),
    .RD_POP   (rd_pop),
    .ERR_CLR  (err_clr),
    .DATA     (data),
    .RX_READY (rx_ready),
    .FRAME_ERR(frame_err),
    .OVERRUN  (overrun),
    .RX_INT   (rx_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       pop_after;
    logic       clr_after;
    int         exp_pulses;
    logic       exp_ready;
    logic [7:0] exp_head;
    logic       exp_fe;
    logic       exp_ov;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one full frame plus an idle gap. pop_tick selects the tick on
  // whose edge RD_POP is high (-1 for none).
  task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_tick,
                            output int pulses, output int first_int);
    pulses    = 0;
    first_int = -1;
    for (int t = 1; t <= FRAME_TICKS + GAP_TICKS; t++) begin
      int k;
      k = (t - 1) / CPB;
      if (t > FRAME_TICKS) rx = 1'b1;
      else if (k == 0)     rx = 1'b0;
      else if (k <= 8)     rx = b[k-1];
      else                 rx = stop;
      rd_pop = (t == pop_tick);
      tick();
      if (rx_int) begin
        pulses++;
        if (first_int < 0) first_int = t;
      end
    end
    rd_pop = 1'b0;
  endtask

  task automatic pop_once();
    rd_pop = 1'b1;
    tick();
    rd_pop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int pulses;
  int first_int;

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    rx      = 1'b1;
    rd_pop  = 1'b0;
    err_clr = 1'b0;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[3] = '{8'h01, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'h02, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[5] = '{8'h03, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[6] = '{8'h04, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[7] = '{8'h05, 1'b1, 1'b0, 1'b0, 0, 1'b1, 8'h01, 1'b0, 1'b1};

    do_reset();
    chk("reset_ready", rx_ready, 0);
    chk("reset_data", data, 0);
    chk("reset_fe", frame_err, 0);
    chk("reset_ov", overrun, 0);
    chk("reset_int", rx_int, 0);

    // Glitch: 3 low cycles must not start a frame.
    rx = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rx = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (rx_int) pulses++;
    end
    chk("glitch_int", pulses, 0);
    chk("glitch_ready", rx_ready, 0);
    chk("glitch_fe", frame_err, 0);
    chk("glitch_ov", overrun, 0);
    send_frame(8'h5A, 1'b1, -1, pulses, first_int);
    chk("after_glitch_pulses", pulses, 1);
    chk("after_glitch_data", data, 8'h5A);
    pop_once();
    chk("after_glitch_pop_ready", rx_ready, 0);

    // Table: single byte, framing error + clear, recovery, fill to overrun.
    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].b, vecs[v].stop, -1, pulses, first_int);
      chk($sformatf("v%0d_pulses", v), pulses, vecs[v].exp_pulses);
      chk($sformatf("v%0d_first_int", v), first_int,
          (vecs[v].exp_pulses != 0) ? PUSH_TICK : -1);
      chk($sformatf("v%0d_ready", v), rx_ready, vecs[v].exp_ready);
      chk($sformatf("v%0d_head", v), data, vecs[v].exp_head);
      chk($sformatf("v%0d_fe", v), frame_err, vecs[v].exp_fe);
      chk($sformatf("v%0d_ov", v), overrun, vecs[v].exp_ov);
      if (vecs[v].pop_after) begin
        pop_once();
        chk($sformatf("v%0d_pop_ready", v), rx_ready, 0);
        chk($sformatf("v%0d_pop_data", v), data, 0);
      end
      if (vecs[v].clr_after) begin
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk($sformatf("v%0d_clr_fe", v), frame_err, 0);
      end
    end

    // Drain after overrun: 0x05 must have been dropped.
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_ready", i), rx_ready, 1);
      chk($sformatf("drain%0d_data", i), data, i + 1);
      pop_once();
    end
    chk("drain_empty_ready", rx_ready, 0);
    chk("drain_empty_data", data, 0);
    pop_once();
    chk("pop_when_empty_ready", rx_ready, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_ov", overrun, 0);

    // Boundary: FIFO full, RD_POP on the stop-sample edge of 0x77.
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, -1, pulses, first_int);
    send_frame(8'h77, 1'b1, PUSH_TICK, pulses, first_int);
    chk("bound_pulses", pulses, 1);
    chk("bound_ov", overrun, 0);
    chk("bound_head", data, 8'h12);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bound_pop%0d", i), data, 8'h12 + i);
      pop_once();
    end
    chk("bound_last", data, 8'h77);
    chk("bound_last_ready", rx_ready, 1);
    pop_once();
    chk("bound_empty", rx_ready, 0);

    // Reset mid-frame with FIFO non-empty and FRAME_ERR set.
    send_frame(8'h99, 1'b0, -1, pulses, first_int);
    send_frame(8'h42, 1'b1, -1, pulses, first_int);
    chk("pre_rst_fe", frame_err, 1);
    chk("pre_rst_ready", rx_ready, 1);
    begin
      logic [7:0] c3;
      c3 = 8'hC3;
      rx = 1'b0;
      for (int i = 0; i < CPB; i++) tick();
      for (int k = 0; k < 4; k++) begin
        rx = c3[k];
        for (int i = 0; i < CPB; i++) tick();
      end
      rx = c3[4];
      for (int i = 0; i < CPB / 2; i++) tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rx  = 1'b1;
    chk("rst_ready", rx_ready, 0);
    chk("rst_data", data, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_ov", overrun, 0);
    chk("rst_int", rx_int, 0);
    for (int i = 0; i < GAP_TICKS; i++) tick();
    chk("rst_idle_ready", rx_ready, 0);
    send_frame(8'hC3, 1'b1, -1, pulses, first_int);
    chk("post_rst_pulses", pulses, 1);
    chk("post_rst_first_int", first_int, PUSH_TICK);
    chk("post_rst_data", data, 8'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
